// File: rtl/soric_bus_pkg.sv
// Shared definitions for the SoRIC bus glue: bridge state encoding
// and default window/error constants.
package soric_bus_pkg;

    localparam int unsigned BUS_DW  = 32;
    localparam int unsigned BUS_BEW = BUS_DW / 8;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
    localparam logic [31:0] DEF_ERR_DATA  = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_DRAIN = 3'd4
    } bridge_state_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Bounded cycle counter: cleared on request, counts while enabled,
// flags terminal count at LIMIT-1 and holds there.
module bus_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    assign o_terminal = (r_cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_terminal) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/wb_inter_bridge.sv
// Wishbone classic slave to req/gnt/rvalid interconnect master bridge
// with window decode, abort draining and response timeout.
module wb_inter_bridge
    import soric_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = BUS_DW,
    parameter logic [31:0] BASE_ADDR      = DEF_BASE_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
    input  logic                    clk_i,
    input  logic                    reset,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    data_req_o,
    output logic [ADDR_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [DATA_WIDTH/8-1:0] data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i,
    output logic                    timeout_o,
    output logic                    busy_o
);

    localparam int unsigned BEW = DATA_WIDTH / 8;

    bridge_state_e r_state;

    logic                  r_req;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [BEW-1:0]        r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_timeout;

    logic w_in_window;
    logic w_tc;
    logic w_cnt_clr;
    logic w_cnt_en;
    logic w_unused;

    assign w_in_window = (wbs_adr_i[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
    assign w_cnt_clr   = (r_state == ST_IDLE);
    assign w_cnt_en    = (r_state == ST_REQ) || (r_state == ST_WAIT)
                      || (r_state == ST_DRAIN);
    assign w_unused    = ^wbs_adr_i[1:0];

    bus_timeout_counter #(
        .LIMIT      (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_i      (clk_i),
        .reset      (reset),
        .i_clear    (w_cnt_clr),
        .i_enable   (w_cnt_en),
        .o_terminal (w_tc)
    );

    always_ff @(posedge clk_i) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_req     <= 1'b0;
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_ack     <= 1'b0;
            r_timeout <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (wbs_stb_i && wbs_cyc_i) begin
                        if (w_in_window) begin
                            r_addr  <= {wbs_adr_i[ADDR_WIDTH-1:2], 2'b00};
                            r_be    <= wbs_sel_i[BEW-1:0];
                            r_we    <= wbs_we_i;
                            r_wdata <= wbs_dat_i;
                            r_req   <= 1'b1;
                            r_state <= ST_REQ;
                        end else begin
                            r_ack   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= ST_ACK;
                        end
                    end
                end
                ST_REQ: begin
                    if (data_gnt_i) begin
                        r_req <= 1'b0;
                        if (data_rvalid_i) begin
                            r_rdata <= r_we ? '0 : data_rdata_i;
                            r_ack   <= wbs_cyc_i;
                            r_state <= wbs_cyc_i ? ST_ACK : ST_IDLE;
                        end else begin
                            r_state <= wbs_cyc_i ? ST_WAIT : ST_DRAIN;
                        end
                    end else if (!wbs_cyc_i) begin
                        r_req   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_tc) begin
                        r_req     <= 1'b0;
                        r_ack     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_rdata   <= r_we ? '0 : ERR_DATA[DATA_WIDTH-1:0];
                        r_state   <= ST_ACK;
                    end
                end
                ST_WAIT: begin
                    if (data_rvalid_i) begin
                        r_rdata <= r_we ? '0 : data_rdata_i;
                        r_ack   <= wbs_cyc_i;
                        r_state <= wbs_cyc_i ? ST_ACK : ST_IDLE;
                    end else if (!wbs_cyc_i) begin
                        r_state <= ST_DRAIN;
                    end else if (w_tc) begin
                        r_ack     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_rdata   <= r_we ? '0 : ERR_DATA[DATA_WIDTH-1:0];
                        r_state   <= ST_ACK;
                    end
                end
                ST_DRAIN: begin
                    // Master has gone; swallow the late response silently.
                    if (data_rvalid_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_tc) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    r_rdata <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o    = r_ack;
    assign wbs_dat_o    = r_rdata;
    assign data_req_o   = r_req;
    assign data_addr_o  = r_addr;
    assign data_we_o    = r_we;
    assign data_be_o    = r_be;
    assign data_wdata_o = r_wdata;
    assign timeout_o    = r_timeout;
    assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_inter_bridge.sv
// Directed bench for wb_inter_bridge: scoreboarded acks, latency,
// window decode, timeout, drain and reset behaviour.
module tb_wb_inter_bridge;

    logic        clk_i = 1'b0;
    logic        reset;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        data_req_o;
    logic [11:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        timeout_o, busy_o;

    typedef struct {
        logic [31:0] dat;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   waited;

    always #5 clk_i = ~clk_i;

    wb_inter_bridge #(
        .ADDR_WIDTH     (12),
        .DATA_WIDTH     (32),
        .BASE_ADDR      (32'h3000_0000),
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk_i         (clk_i),
        .reset         (reset),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .data_req_o    (data_req_o),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_gnt_i    (data_gnt_i),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .timeout_o     (timeout_o),
        .busy_o        (busy_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] adr, input logic we,
                         input logic [3:0] sel, input logic [31:0] dat,
                         input bit push, input logic [31:0] edat,
                         input logic eto);
        exp_t e;
        wbs_adr_i = adr;
        wbs_we_i  = we;
        wbs_sel_i = sel;
        wbs_dat_i = dat;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        if (push) begin
            e.dat = edat;
            e.to  = eto;
            sb.push_back(e);
        end
    endtask

    task automatic release_bus();
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    // Waits up to budget cycles for ack, then checks it against the queue head.
    task automatic expect_ack(input string tag, input int budget,
                              output int n);
        exp_t e;
        n = 0;
        while (wbs_ack_o !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_ack"}, {31'd0, wbs_ack_o}, 32'd1);
        if (wbs_ack_o === 1'b1) begin
            chk({tag, "_sb"}, {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_dat"}, wbs_dat_o, e.dat);
                chk({tag, "_to"}, {31'd0, timeout_o}, {31'd0, e.to});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
        step();
        step();
        chk("rst_req", {31'd0, data_req_o}, 0);
        chk("rst_ack", {31'd0, wbs_ack_o}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_to", {31'd0, timeout_o}, 0);
        chk("rst_dat", wbs_dat_o, 0);
        chk("rst_addr", {20'd0, data_addr_o}, 0);
        reset = 1'b0;
        step();

        // zero-wait read
        issue(32'h3000_0010, 0, 4'hF, 0, 1, 32'h1234_5678, 0);
        step();
        chk("rd_req", {31'd0, data_req_o}, 1);
        chk("rd_addr", {20'd0, data_addr_o}, 32'h010);
        chk("rd_we", {31'd0, data_we_o}, 0);
        chk("rd_be", {28'd0, data_be_o}, 32'hF);
        chk("rd_noack", {31'd0, wbs_ack_o}, 0);
        data_gnt_i = 1;
        step();
        data_gnt_i = 0;
        chk("rd_req_drop", {31'd0, data_req_o}, 0);
        data_rvalid_i = 1;
        data_rdata_i  = 32'h1234_5678;
        step();
        data_rvalid_i = 0;
        data_rdata_i  = 32'h0BAD_0BAD;
        expect_ack("rd", 0, waited);
        step();
        chk("rd_ack1", {31'd0, wbs_ack_o}, 0);
        chk("rd_idle", {31'd0, busy_o}, 0);
        release_bus();
        step();
        chk("rd_noreacc", {31'd0, data_req_o}, 0);

        // write with late grant
        issue(32'h3000_0FFF, 1, 4'b0011, 32'hA5A5_A5A5, 1, 0, 0);
        step();
        chk("wr_addr", {20'd0, data_addr_o}, 32'hFFC);
        chk("wr_be", {28'd0, data_be_o}, 32'h3);
        chk("wr_we", {31'd0, data_we_o}, 1);
        chk("wr_wdata", data_wdata_o, 32'hA5A5_A5A5);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wr_req_hold", {31'd0, data_req_o}, 1);
        end
        data_gnt_i = 1;
        step();
        data_gnt_i = 0;
        chk("wr_req_drop", {31'd0, data_req_o}, 0);
        chk("wr_noack", {31'd0, wbs_ack_o}, 0);
        data_rvalid_i = 1;
        step();
        data_rvalid_i = 0;
        expect_ack("wr", 0, waited);
        step();
        chk("wr_ack1", {31'd0, wbs_ack_o}, 0);
        release_bus();
        step();

        // out of window
        data_rdata_i = 32'h5555_AAAA;
        issue(32'h2000_0000, 0, 4'hF, 0, 1, 0, 0);
        step();
        chk("oow_req", {31'd0, data_req_o}, 0);
        expect_ack("oow", 0, waited);
        release_bus();
        step();
        chk("oow_ack1", {31'd0, wbs_ack_o}, 0);
        chk("oow_req2", {31'd0, data_req_o}, 0);

        // timeout on read
        issue(32'h3000_0020, 0, 4'hF, 0, 1, 32'hDEAD_BEEF, 1);
        step();
        data_gnt_i = 1;
        step();
        data_gnt_i = 0;
        expect_ack("tmo", 10, waited);
        chk("tmo_lat", waited, 7);
        chk("tmo_busy", {31'd0, busy_o}, 1);
        step();
        chk("tmo_busy_clr", {31'd0, busy_o}, 0);
        chk("tmo_pulse", {31'd0, timeout_o}, 0);
        release_bus();
        step();

        // cycle dropped in WAIT, late response drained
        issue(32'h3000_0030, 0, 4'hF, 0, 0, 0, 0);
        step();
        data_gnt_i = 1;
        step();
        data_gnt_i = 0;
        release_bus();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drn_noack", {31'd0, wbs_ack_o}, 0);
            chk("drn_busy", {31'd0, busy_o}, 1);
        end
        data_rvalid_i = 1;
        step();
        data_rvalid_i = 0;
        chk("drn_idle", {31'd0, busy_o}, 0);
        chk("drn_noack2", {31'd0, wbs_ack_o}, 0);
        chk("drn_noto", {31'd0, timeout_o}, 0);

        // grant and response in the same cycle
        issue(32'h3000_0044, 0, 4'hF, 0, 1, 32'hCAFE_F00D, 0);
        step();
        chk("ff_addr", {20'd0, data_addr_o}, 32'h044);
        data_gnt_i = 1;
        data_rvalid_i = 1;
        data_rdata_i = 32'hCAFE_F00D;
        step();
        data_gnt_i = 0;
        data_rvalid_i = 0;
        expect_ack("ff", 0, waited);
        release_bus();
        step();
        chk("sb_empty", sb.size(), 0);

        // reset while in REQ
        issue(32'h3000_0050, 1, 4'hC, 32'h1111_2222, 0, 0, 0);
        step();
        chk("rr_req", {31'd0, data_req_o}, 1);
        reset = 1'b1;
        step();
        chk("rr_req0", {31'd0, data_req_o}, 0);
        chk("rr_ack0", {31'd0, wbs_ack_o}, 0);
        chk("rr_busy0", {31'd0, busy_o}, 0);
        chk("rr_addr0", {20'd0, data_addr_o}, 0);
        chk("rr_be0", {28'd0, data_be_o}, 0);
        chk("rr_wd0", data_wdata_o, 0);
        chk("rr_we0", {31'd0, data_we_o}, 0);
        reset = 1'b0;
        release_bus();
        step();
        chk("rr_noack", {31'd0, wbs_ack_o}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_inter_bridge.md
# wb_inter_bridge

Wishbone classic slave that converts Caravel management-SoC accesses into request/grant/rvalid transactions on one master port of the read/write interconnect. It sits between the Wishbone bus and interconnect master port 2, and replaces the current combinational glue. Adds address-window decoding, registered request capture, abort handling on cycle drop, and a response timeout so a stalled slave can never hang the management core.

## Interface
Parameters:
- ADDR_WIDTH, 12, interconnect byte-address width
- DATA_WIDTH, 32, data width (byte enables = DATA_WIDTH/8)
- BASE_ADDR, 32'h3000_0000, Wishbone window base; bits [31:ADDR_WIDTH] must match
- TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before forced completion (≥2)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- clk_i  in  1  clock
- reset  in  1  synchronous, active-high
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone strobe/cycle/write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  one-cycle acknowledge
- wbs_dat_o  out  32  read data, valid with ack
- data_req_o  out  1  interconnect request
- data_addr_o  out  ADDR_WIDTH  word-aligned address
- data_we_o  out  1  write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  write data
- data_gnt_i  in  1  grant
- data_rvalid_i  in  1  response valid (reads and writes)
- data_rdata_i  in  32  read data
- timeout_o  out  1  one-cycle pulse with timed-out ack
- busy_o  out  1  high in any state except IDLE

## Operation
- States: IDLE, REQ, WAIT, ACK, DRAIN.
- IDLE: on stb&cyc, in window → capture {adr[ADDR_WIDTH-1:2],2'b00}, sel, we, dat; go REQ. Out of window → go ACK with wbs_dat_o=0, no interconnect request.
- REQ: data_req_o=1, fields stable from captured registers. gnt&rvalid same cycle → latch rdata, ACK. gnt only → WAIT. cyc dropped before gnt → IDLE, req deasserts next cycle.
- WAIT: rvalid → latch rdata (reads; writes latch 0), ACK. cyc dropped → DRAIN.
- DRAIN: no ack; wait for rvalid (discarded) or timeout, then IDLE.
- ACK: wbs_ack_o=1 one cycle, wbs_dat_o holds latched data; → IDLE unconditionally.
- Timeout counter: cleared on leaving IDLE, increments each cycle in REQ/WAIT/DRAIN. Reaching TIMEOUT_CYCLES-1 without completion → ACK with ERR_DATA (reads) and timeout_o=1 (DRAIN → IDLE, no ack, timeout_o=1). Completion in the same cycle wins over timeout.
- Stray rvalid in IDLE/ACK is ignored.
- Counter width $clog2(TIMEOUT_CYCLES+1); no wrap possible.

## Timing
- Reset: all outputs 0, state IDLE, counter 0, captured registers 0. Reset mid-transaction drops data_req_o on the next edge with no ack.
- Accept at edge T → data_req_o high from T+1.
- Zero-wait slave (gnt at T+1, rvalid at T+2) → wbs_ack_o at T+3.
- Out-of-window access accepted at T → ack at T+1.
- After ack the bridge spends one cycle in IDLE before it can accept, so a held stb is not double-counted.
- Outputs are fully registered; no combinational path from Wishbone inputs to interconnect outputs.

## Structure
- Shared package soric_bus_pkg: state enum encoding, ERR_DATA default, BASE_ADDR default, byte-enable width constant.
- One sub-module is natural: bus_timeout_counter (clear, enable, terminal-count output), reusable by uart_to_mem.
- Instantiated at interconnect master index 2, in place of the existing assigns.

## Test plan
- Read 0x3000_0010, slave gnt T+1 and rvalid T+2 with 0x1234_5678 → data_addr_o=0x010, ack at T+3, wbs_dat_o=0x1234_5678.
- Write 0x3000_0FFF with sel=4'b0011 and dat=0xA5A5_A5A5, gnt delayed 5 cycles → addr 0xFFC, be=0011, req held until gnt, one ack after rvalid.
- Access 0x2000_0000 → no data_req_o, ack at T+1, dat=0.
- Read with gnt but no rvalid, TIMEOUT_CYCLES=8 → ack with 0xDEAD_BEEF, timeout_o pulses with it, busy_o clears next cycle.
- cyc dropped in WAIT, rvalid arrives 3 cycles later → no ack, DRAIN→IDLE; next read completes normally.
- Assert reset while in REQ → data_req_o=0 next cycle; all outputs 0; no ack.
